// File: rtl/alu_pkg.sv
// alu_pkg: FSM state, opcode and error-result definitions shared by the ALU sharing controller,
// plus helpers that classify opcodes and give each one its settle latency.
package alu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1111;
  localparam logic [63:0] ERR_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;
  function automatic logic is_div(input logic [3:0] sel);
    return sel == OP_DIV || sel == OP_MOD;
  endfunction
  function automatic logic [3:0] op_cycles(input logic [3:0] sel, input int mul_cycles, input int div_cycles);
    return sel == OP_MUL ? 4'(mul_cycles) : is_div(sel) ? 4'(div_cycles) : 4'd1;
  endfunction
endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: combinational two-way round-robin grant; prio names the requester favoured on a tie.
module alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant0,
  output logic grant1
);
  assign grant0 = valid0 && (!valid1 || !prio);
  assign grant1 = valid1 && (!valid0 || prio);
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters with round-robin grant,
// per-op settle latency and a tagged valid/ready response. ALU_SHARE_ERRCHK_EN enables divide-by-zero trapping.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [63:0] alu_out,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_out,
  output logic        resp_err
);
  state_t      state;
  logic        prio;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        skip;
  logic [3:0]  cnt;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  alu_rr_arb2 u_arb (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .prio  (prio),
    .grant0(grant0),
    .grant1(grant1)
  );
  // readys are forced low while reset is held, not just after the state register clears
  assign req0_ready = rst_n && state == ST_IDLE && grant0;
  assign req1_ready = rst_n && state == ST_IDLE && grant1;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign a          = grant1 ? req1_a : req0_a;
  assign b          = grant1 ? req1_b : req0_b;
  assign sel        = grant1 ? req1_sel : req0_sel;
  assign resp_valid = state == ST_RESP;
`ifdef ALU_SHARE_ERRCHK_EN
  assign skip = is_div(sel) && b == 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_err <= 1'b0;
    else if (accept) resp_err <= skip;
`else
  assign skip     = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      prio     <= 1'b0;
      cnt      <= 4'd0;
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_sel  <= 4'd0;
      resp_id  <= 1'b0;
      resp_out <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          alu_a   <= a;
          alu_b   <= b;
          alu_sel <= sel;
          resp_id <= grant1;
          cnt     <= op_cycles(sel, MUL_CYCLES, DIV_CYCLES);
          state   <= skip ? ST_RESP : ST_EXEC;
          if (skip) resp_out <= ERR_RESULT;
        end
        ST_EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            resp_out <= alu_out;
            state    <= ST_RESP;
          end
        end
        ST_RESP: if (resp_ready) begin
          state <= ST_IDLE;
          prio  <= ~resp_id;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of the ALU sharing controller against a behavioural ALU model.
module tb_alu_share_ctrl;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [3:0]  req0_sel, req1_sel, alu_sel;
  logic [63:0] alu_out, resp_out;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_share_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out), .resp_err(resp_err)
  );
  always_comb begin
    alu_out = 64'd0;
    case (alu_sel)
      OP_ADD:  alu_out = {32'd0, alu_a + alu_b};
      OP_SUB:  alu_out = {32'd0, alu_a - alu_b};
      OP_MUL:  alu_out = {32'd0, alu_a} * {32'd0, alu_b};
      OP_DIV, OP_MOD: alu_out = alu_b == 32'd0 ? 64'd0 : {30'd0, 18'(alu_a % alu_b), 16'(alu_a / alu_b)};
      OP_AND:  alu_out = {32'd0, alu_a & alu_b};
      OP_OR:   alu_out = {32'd0, alu_a | alu_b};
      OP_XOR:  alu_out = {32'd0, alu_a ^ alu_b};
      default: alu_out = {32'd0, alu_a ~^ alu_b};
    endcase
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    #1 check("accept_ready", id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  task automatic wait_resp(input string tag, input int lat, input logic [63:0] out, input logic id, input logic err);
    int k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (resp_valid) break;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_out"}, resp_out, out);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_err"}, resp_err, err);
  endtask
  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("resp_cleared", resp_valid, 1'b0);
  endtask
  initial begin
    int n, m, last, cyc;
    logic seen;
    rst_n = 1'b0;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sel = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sel = OP_ADD;
    #1;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_sel", alu_sel, 4'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_out", resp_out, 64'd0);
    check("rst_resp_id", resp_id, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd5310, 32'd112, OP_ADD);
    wait_resp("add", 1, 64'd5422, 1'b0, 1'b0);
    consume();
    issue(1'b1, 32'd5310, 32'd112, OP_MUL);
    wait_resp("mul", 2, 64'd594720, 1'b1, 1'b0);
    consume();
    issue(1'b0, 32'd5310, 32'd112, OP_DIV);
    wait_resp("div", 4, 64'h0000_0000_002E_002F, 1'b0, 1'b0);
    consume();
    issue(1'b1, 32'd5310, 32'd112, OP_AND);
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_sel = OP_ADD;
    wait_resp("and", 1, 64'd48, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_out", resp_out, 64'd48);
      check("hold_id", resp_id, 1'b1);
      check("hold_ready0", req0_ready, 1'b0);
      check("hold_ready1", req1_ready, 1'b0);
      check("hold_alu_sel", alu_sel, OP_AND);
    end
    req0_valid = 1'b0;
    consume();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd5310; req0_b = 32'd112; req0_sel = OP_SUB;
    req1_valid = 1'b1; req1_a = 32'd5310; req1_b = 32'd112; req1_sel = OP_XOR;
    resp_ready = 1'b1;
    n = 0; m = 0; last = -1; cyc = 0;
    while (m < 4 && cyc < 60) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("alt_grant", req1_ready, n[0]);
        if (last >= 0) check("alt_gap", 64'(cyc - last), 64'd3);
        last = cyc;
        n++;
      end
      if (resp_valid) begin
        check("alt_resp_id", resp_id, m[0]);
        check("alt_resp_out", resp_out, m[0] ? 64'h14CE : 64'd5198);
        m++;
        if (m == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("alt_responses", 64'(m), 64'd4);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("alt_drained", resp_valid, 1'b0);
    issue(1'b0, 32'd5310, 32'd0, OP_DIV);
`ifdef ALU_SHARE_ERRCHK_EN
    wait_resp("divzero", 1, ERR_RESULT, 1'b0, 1'b1);
`else
    wait_resp("divzero", 4, 64'd0, 1'b0, 1'b0);
`endif
    check("divzero_alu_sel", alu_sel, OP_DIV);
    consume();
    issue(1'b1, 32'd5310, 32'd112, OP_DIV);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_b", alu_b, 32'd0);
    check("abort_alu_sel", alu_sel, 4'd0);
    check("abort_resp_id", resp_id, 1'b0);
    check("abort_resp_out", resp_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen |= resp_valid;
    end
    check("abort_no_resp", seen, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
